// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch slice: superscalar width default,
// instruction buffer depth default, dispatch FSM state enum and the
// dispatch packet payload.
// Macro N_WAY (optional): superscalar width; defaults to 3 when not defined.
`ifndef N_WAY
`define N_WAY 3
`endif

package dispatch_ctrl_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned N_WAY_DEF      = `N_WAY;
    localparam int unsigned IBUF_DEPTH_DEF = 8;

    typedef enum logic {
        DC_RUN      = 1'b0,
        DC_REDIRECT = 1'b1
    } DISP_CTRL_STATE;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } DISPATCH_PACKET_R10K;

endpackage

// File: rtl/dispatch_ctrl_ibuf_fifo.sv
// Multi-push / multi-pop circular instruction buffer.
// Ports:
//   clock, reset      clock, synchronous active-high reset
//   flush             discard all entries (head jumps to tail)
//   push_cnt          number of lanes (from lane 0) written at tail
//   push_packet/br    lane payloads and branch flags
//   pop_cnt           number of head entries retired this cycle
//   count             current occupancy (0..DEPTH)
//   head_packet/br    the N_WAY oldest entries, head first
module dispatch_ctrl_ibuf_fifo
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned N_WAY = N_WAY_DEF,
    parameter int unsigned DEPTH = IBUF_DEPTH_DEF,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [CNT_W-1:0]                push_cnt,
    input  DISPATCH_PACKET_R10K [N_WAY-1:0] push_packet,
    input  logic [N_WAY-1:0]                push_br,
    input  logic [CNT_W-1:0]                pop_cnt,
    output logic [CNT_W-1:0]                count,
    output DISPATCH_PACKET_R10K [N_WAY-1:0] head_packet,
    output logic [N_WAY-1:0]                head_br
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    DISPATCH_PACKET_R10K mem_packet [DEPTH];
    logic [DEPTH-1:0]    mem_br;
    logic [CNT_W-1:0]    head;
    logic [CNT_W-1:0]    tail;

    // Extra pointer bit makes tail - head range over 0..DEPTH
    assign count = tail - head;

    // Head window read, wrapping modulo DEPTH
    always_comb begin
        head_packet = '0;
        head_br     = '0;
        for (int unsigned i = 0; i < N_WAY; i++) begin
            head_packet[i] = mem_packet[head[IDX_W-1:0] + IDX_W'(i)];
            head_br[i]     = mem_br[head[IDX_W-1:0] + IDX_W'(i)];
        end
    end

    // Pointer and storage update
    always_ff @(posedge clock) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            mem_br <= '0;
            for (int unsigned d = 0; d < DEPTH; d++) begin
                mem_packet[d] <= '0;
            end
        end else if (flush) begin
            head <= tail;
        end else begin
            for (int unsigned i = 0; i < N_WAY; i++) begin
                if (CNT_W'(i) < push_cnt) begin
                    mem_packet[tail[IDX_W-1:0] + IDX_W'(i)] <= push_packet[i];
                    mem_br[tail[IDX_W-1:0] + IDX_W'(i)]     <= push_br[i];
                end
            end
            head <= head + pop_cnt;
            tail <= tail + push_cnt;
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order N-way dispatch scheduler between fetch and the R10K back end.
// Buffers fetched lanes, dispatches as many head entries per cycle as the
// ROB, RS and free list can all accept (branch-limited), and on a
// mispredict flushes the buffer and raises a one-cycle fetch redirect.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   fetch_valid/packet/br        fetched lanes (contiguous from lane 0)
//   fetch_ready                  buffer can take a full N_WAY group
//   rob_free, rs_free, fl_free   back-end free counts, saturated at N_WAY
//   branch_haz, br_target        mispredict and redirect PC
//   dispatch_out, dispatched     head entries and thermometer dispatch mask
//   branch_inst                  dispatched lanes holding a branch
//   redirect_valid, redirect_pc  fetch restart request
//   perf_cnt                     stall/flush counters (DISPATCH_CTRL_PERF_EN only)
// Optional feature macro: DISPATCH_CTRL_PERF_EN.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned N_WAY            = N_WAY_DEF,
    parameter int unsigned IBUF_DEPTH       = IBUF_DEPTH_DEF,
    parameter int unsigned MAX_BR_PER_CYCLE = 1,
    localparam int unsigned FREE_W = $clog2(N_WAY) + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_WAY-1:0]                fetch_valid,
    input  DISPATCH_PACKET_R10K [N_WAY-1:0] fetch_packet,
    input  logic [N_WAY-1:0]                fetch_br,
    output logic                            fetch_ready,
    input  logic [FREE_W-1:0]               rob_free,
    input  logic [FREE_W-1:0]               rs_free,
    input  logic [FREE_W-1:0]               fl_free,
    input  logic                            branch_haz,
    input  logic [XLEN-1:0]                 br_target,
    output DISPATCH_PACKET_R10K [N_WAY-1:0] dispatch_out,
    output logic [N_WAY-1:0]                dispatched,
    output logic [N_WAY-1:0]                branch_inst,
    output logic                            redirect_valid,
    output logic [XLEN-1:0]                 redirect_pc
`ifdef DISPATCH_CTRL_PERF_EN
    ,
    output logic [5:0][31:0]                perf_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(IBUF_DEPTH) + 1;

    DISP_CTRL_STATE                  state;
    DISP_CTRL_STATE                  state_next;
    logic [CNT_W-1:0]                count;
    logic [CNT_W-1:0]                push_cnt;
    logic [CNT_W-1:0]                pop_cnt;
    logic [CNT_W-1:0]                avail_n;
    logic [CNT_W-1:0]                br_lim;
    int unsigned                     br_seen;
    logic                            flush;
    logic                            dispatch_en;
    DISPATCH_PACKET_R10K [N_WAY-1:0] head_packet;
    logic [N_WAY-1:0]                head_br;

    dispatch_ctrl_ibuf_fifo #(
        .N_WAY (N_WAY),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .push_cnt    (push_cnt),
        .push_packet (fetch_packet),
        .push_br     (fetch_br),
        .pop_cnt     (pop_cnt),
        .count       (count),
        .head_packet (head_packet),
        .head_br     (head_br)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= DC_RUN;
        else       state <= state_next;
    end

    // Redirect target, re-latched on every mispredict
    always_ff @(posedge clock) begin
        if (reset)           redirect_pc <= '0;
        else if (branch_haz) redirect_pc <= br_target;
    end

    // FSM next state and control
    always_comb begin
        state_next     = state;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        dispatch_en    = 1'b0;
        case (state)
            DC_RUN: begin
                // Pre-dequeue occupancy: conservative free-space check
                fetch_ready = (CNT_W'(IBUF_DEPTH) - count) >= CNT_W'(N_WAY);
                dispatch_en = !branch_haz;
                if (branch_haz) begin
                    flush      = 1'b1;
                    state_next = DC_REDIRECT;
                end
            end
            DC_REDIRECT: begin
                redirect_valid = 1'b1;
                flush          = branch_haz;
                state_next     = branch_haz ? DC_REDIRECT : DC_RUN;
            end
            default: state_next = DC_RUN;
        endcase
    end

    // Lanes accepted from fetch
    always_comb begin
        push_cnt = '0;
        if (fetch_ready && !branch_haz) begin
            for (int unsigned i = 0; i < N_WAY; i++) begin
                push_cnt = push_cnt + CNT_W'(fetch_valid[i]);
            end
        end
    end

    // Dispatch width: min of occupancy and free counts, cut before the excess branch
    always_comb begin
        avail_n = CNT_W'(N_WAY);
        if (count < avail_n)               avail_n = count;
        if (CNT_W'(rob_free) < avail_n)    avail_n = CNT_W'(rob_free);
        if (CNT_W'(rs_free) < avail_n)     avail_n = CNT_W'(rs_free);
        if (CNT_W'(fl_free) < avail_n)     avail_n = CNT_W'(fl_free);
        br_lim  = CNT_W'(N_WAY);
        br_seen = 0;
        for (int unsigned i = 0; i < N_WAY; i++) begin
            if (head_br[i]) begin
                br_seen = br_seen + 1;
                if (br_seen == MAX_BR_PER_CYCLE + 1) br_lim = CNT_W'(i);
            end
        end
        pop_cnt = '0;
        if (dispatch_en) pop_cnt = (br_lim < avail_n) ? br_lim : avail_n;
    end

    // Dispatch outputs
    always_comb begin
        dispatched   = '0;
        dispatch_out = head_packet;
        for (int unsigned i = 0; i < N_WAY; i++) begin
            dispatched[i]         = CNT_W'(i) < pop_cnt;
            dispatch_out[i].valid = dispatched[i];
        end
        branch_inst = dispatched & head_br;
    end

`ifdef DISPATCH_CTRL_PERF_EN
    // Cause order: rob, rs, fl, empty, branch limit, flush
    logic [5:0] perf_hit;

    // First cause in list order whose limit equals the granted width
    always_comb begin
        perf_hit = '0;
        if (branch_haz && state == DC_RUN) begin
            perf_hit[5] = 1'b1;
        end else if (pop_cnt < CNT_W'(N_WAY)) begin
            if (CNT_W'(rob_free) == pop_cnt)     perf_hit[0] = 1'b1;
            else if (CNT_W'(rs_free) == pop_cnt) perf_hit[1] = 1'b1;
            else if (CNT_W'(fl_free) == pop_cnt) perf_hit[2] = 1'b1;
            else if (count == pop_cnt)           perf_hit[3] = 1'b1;
            else if (br_lim == pop_cnt)          perf_hit[4] = 1'b1;
        end
    end

    // Saturating counters
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cnt <= '0;
        end else begin
            for (int unsigned k = 0; k < 6; k++) begin
                if (perf_hit[k] && perf_cnt[k] != '1) perf_cnt[k] <= perf_cnt[k] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
`timescale 1ns/1ps
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    localparam int unsigned NW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned MAXBR = 1;
    localparam int unsigned FW    = $clog2(NW) + 1;

    logic                         clock = 1'b0;
    logic                         reset;
    logic [NW-1:0]                fetch_valid;
    DISPATCH_PACKET_R10K [NW-1:0] fetch_packet;
    logic [NW-1:0]                fetch_br;
    logic                         fetch_ready;
    logic [FW-1:0]                rob_free, rs_free, fl_free;
    logic                         branch_haz;
    logic [XLEN-1:0]              br_target;
    DISPATCH_PACKET_R10K [NW-1:0] dispatch_out;
    logic [NW-1:0]                dispatched;
    logic [NW-1:0]                branch_inst;
    logic                         redirect_valid;
    logic [XLEN-1:0]              redirect_pc;

    always #5 clock = ~clock;

    dispatch_ctrl #(
        .N_WAY            (NW),
        .IBUF_DEPTH       (DEPTH),
        .MAX_BR_PER_CYCLE (MAXBR)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_valid    (fetch_valid),
        .fetch_packet   (fetch_packet),
        .fetch_br       (fetch_br),
        .fetch_ready    (fetch_ready),
        .rob_free       (rob_free),
        .rs_free        (rs_free),
        .fl_free        (fl_free),
        .branch_haz     (branch_haz),
        .br_target      (br_target),
        .dispatch_out   (dispatch_out),
        .dispatched     (dispatched),
        .branch_inst    (branch_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Reference model: FIFO of in-flight instructions plus redirect flag
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          br;
    } entry_t;

    entry_t        q[$];
    bit            m_redir;
    logic [31:0]   m_rpc;
    int            exp_n;
    bit            exp_fr;
    logic [NW-1:0] em, eb;
    logic [31:0]   pc_seq = 32'h1000;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic set_fetch(input int lanes, input logic [NW-1:0] br);
        for (int i = 0; i < int'(NW); i++) begin
            fetch_valid[i]        = (i < lanes);
            fetch_br[i]           = br[i] && (i < lanes);
            fetch_packet[i].valid = (i < lanes);
            fetch_packet[i].pc    = pc_seq + 32'(4 * i);
            fetch_packet[i].inst  = $urandom;
        end
        pc_seq = pc_seq + 32'(4 * lanes);
    endtask

    task automatic set_free(input int r, input int s, input int f);
        rob_free = FW'(r);
        rs_free  = FW'(s);
        fl_free  = FW'(f);
    endtask

    // Expected dispatch width, masks and fetch_ready from the model
    task automatic predict();
        int k, nb;
        k = q.size();
        if (int'(rob_free) < k) k = int'(rob_free);
        if (int'(rs_free)  < k) k = int'(rs_free);
        if (int'(fl_free)  < k) k = int'(fl_free);
        if (k > int'(NW))       k = int'(NW);
        if (m_redir || branch_haz) k = 0;
        exp_n = k;
        nb    = 0;
        for (int j = 0; j < k; j++) begin
            if (q[j].br) begin
                nb++;
                if (nb > int'(MAXBR)) begin
                    exp_n = j;
                    break;
                end
            end
        end
        for (int i = 0; i < int'(NW); i++) begin
            em[i] = (i < exp_n);
            eb[i] = (i < exp_n) && q[i].br;
        end
        exp_fr = !m_redir && (int'(DEPTH) - q.size() >= int'(NW));
    endtask

    // Advance the model with the current inputs, then move to the next negedge
    task automatic tick();
        entry_t e;
        predict();
        if (reset) begin
            q.delete();
            m_redir = 0;
            m_rpc   = '0;
        end else if (branch_haz) begin
            q.delete();
            m_redir = 1;
            m_rpc   = br_target;
        end else begin
            for (int j = 0; j < exp_n; j++) void'(q.pop_front());
            if (exp_fr) begin
                for (int i = 0; i < int'(NW); i++) begin
                    if (fetch_valid[i]) begin
                        e.pc   = fetch_packet[i].pc;
                        e.inst = fetch_packet[i].inst;
                        e.br   = fetch_br[i];
                        q.push_back(e);
                    end
                end
            end
            m_redir = 0;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        branch_haz = 1'b0;
        br_target  = '0;
        fetch_packet = '0;
        set_fetch(0, '0);
        set_free(3, 3, 3);
        tick();
        tick();
        #1;
        n_checks++;
        if (dispatched !== '0 || branch_inst !== '0 || redirect_valid !== 1'b0 ||
            redirect_pc !== '0 || fetch_ready !== 1'b1 || dispatch_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: disp=%b br=%b rv=%b rpc=%h fr=%b out=%h, want all 0 and fr=1",
                     dispatched, branch_inst, redirect_valid, redirect_pc, fetch_ready, dispatch_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_dispatch();
        set_free(3, 3, 3);
        set_fetch(3, '0);
        #1;
        n_checks++;
        if (dispatched !== 3'b000 || fetch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_bypass: disp=%b fr=%b, want 000 and 1", dispatched, fetch_ready);
        end
        tick();
        set_fetch(0, '0);
        #1;
        n_checks++;
        if (dispatched !== 3'b111 || dispatch_out[0].pc !== q[0].pc ||
            dispatch_out[1].pc !== q[1].pc || dispatch_out[2].pc !== q[2].pc || branch_inst !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_dispatch: disp=%b pcs=%h %h %h, want 111 pcs=%h %h %h",
                     dispatched, dispatch_out[0].pc, dispatch_out[1].pc, dispatch_out[2].pc,
                     q[0].pc, q[1].pc, q[2].pc);
        end
        tick();
        #1;
        n_checks++;
        if (dispatched !== 3'b000) begin
            n_fail++;
            $display("FAIL drained_empty: disp=%b, want 000", dispatched);
        end
    endtask

    task automatic test_free_limit();
        logic [31:0] next_pc;
        set_free(0, 0, 0);
        set_fetch(3, '0);
        tick();
        set_fetch(2, '0);
        tick();
        set_fetch(0, '0);
        set_free(1, 3, 2);
        #1;
        n_checks++;
        if (dispatched !== 3'b001 || dispatch_out[0].pc !== q[0].pc) begin
            n_fail++;
            $display("FAIL free_limit: disp=%b pc=%h, want 001 pc=%h", dispatched, dispatch_out[0].pc, q[0].pc);
        end
        next_pc = q[1].pc;
        tick();
        set_free(3, 3, 3);
        #1;
        n_checks++;
        if (dispatched !== 3'b111 || dispatch_out[0].pc !== next_pc) begin
            n_fail++;
            $display("FAIL head_advance: disp=%b pc=%h, want 111 pc=%h", dispatched, dispatch_out[0].pc, next_pc);
        end
        tick();
        #1;
        n_checks++;
        if (dispatched !== 3'b001 || dispatch_out[0].pc !== q[0].pc) begin
            n_fail++;
            $display("FAIL free_tail: disp=%b pc=%h, want 001 pc=%h", dispatched, dispatch_out[0].pc, q[0].pc);
        end
        tick();
    endtask

    task automatic test_full();
        set_free(0, 0, 0);
        set_fetch(3, '0);
        tick();
        set_fetch(3, '0);
        #1;
        n_checks++;
        if (fetch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_at_3: fr=%b, want 1", fetch_ready);
        end
        tick();
        set_fetch(3, '0);
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0 || dispatched !== 3'b000) begin
            n_fail++;
            $display("FAIL ready_at_6: fr=%b disp=%b, want 0 000", fetch_ready, dispatched);
        end
        tick();
        tick();
        set_fetch(0, '0);
        set_free(3, 3, 3);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (dispatched !== 3'b111 || dispatch_out[0].pc !== q[0].pc ||
                dispatch_out[2].pc !== q[2].pc) begin
                n_fail++;
                $display("FAIL full_drain%0d: disp=%b pc0=%h pc2=%h, want 111 %h %h",
                         c, dispatched, dispatch_out[0].pc, dispatch_out[2].pc, q[0].pc, q[2].pc);
            end
            tick();
        end
        #1;
        n_checks++;
        if (dispatched !== 3'b000) begin
            n_fail++;
            $display("FAIL full_no_extra: disp=%b, want 000", dispatched);
        end
    endtask

    task automatic test_branch_limit();
        set_free(0, 0, 0);
        set_fetch(3, 3'b011);
        tick();
        set_fetch(0, '0);
        set_free(3, 3, 3);
        #1;
        n_checks++;
        if (dispatched !== 3'b001 || branch_inst !== 3'b001) begin
            n_fail++;
            $display("FAIL br_limit_first: disp=%b br=%b, want 001 001", dispatched, branch_inst);
        end
        tick();
        #1;
        n_checks++;
        if (dispatched !== 3'b011 || branch_inst !== 3'b001) begin
            n_fail++;
            $display("FAIL br_limit_second: disp=%b br=%b, want 011 001", dispatched, branch_inst);
        end
        tick();
    endtask

    task automatic test_flush();
        set_free(0, 0, 0);
        set_fetch(3, '0);
        tick();
        set_fetch(1, '0);
        tick();
        set_fetch(0, '0);
        set_free(3, 3, 3);
        branch_haz = 1'b1;
        br_target  = 32'h40;
        #1;
        n_checks++;
        if (dispatched !== 3'b000 || branch_inst !== 3'b000 || dispatch_out[0].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_block: disp=%b br=%b v0=%b, want 000 000 0",
                     dispatched, branch_inst, dispatch_out[0].valid);
        end
        tick();
        branch_haz = 1'b0;
        set_fetch(3, '0);
        #1;
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40 || fetch_ready !== 1'b0 || dispatched !== 3'b000) begin
            n_fail++;
            $display("FAIL redirect: rv=%b rpc=%h fr=%b disp=%b, want 1 00000040 0 000",
                     redirect_valid, redirect_pc, fetch_ready, dispatched);
        end
        tick();
        set_fetch(0, '0);
        #1;
        n_checks++;
        if (redirect_valid !== 1'b0 || fetch_ready !== 1'b1 || dispatched !== 3'b000) begin
            n_fail++;
            $display("FAIL back_to_run: rv=%b fr=%b disp=%b, want 0 1 000", redirect_valid, fetch_ready, dispatched);
        end
        // Back-to-back mispredicts re-latch the target
        branch_haz = 1'b1;
        br_target  = 32'h80;
        tick();
        br_target  = 32'h9c;
        tick();
        branch_haz = 1'b0;
        #1;
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h9c) begin
            n_fail++;
            $display("FAIL relatch: rv=%b rpc=%h, want 1 0000009c", redirect_valid, redirect_pc);
        end
        // Reset in the middle of a redirect
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== '0 || fetch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_redirect: rv=%b rpc=%h fr=%b, want 0 0 1", redirect_valid, redirect_pc, fetch_ready);
        end
    endtask

    task automatic test_random();
        int guard;
        for (int c = 0; c < 60; c++) begin
            set_fetch($urandom_range(0, 3), NW'($urandom));
            set_free($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            branch_haz = ($urandom_range(0, 19) == 0);
            br_target  = $urandom & 32'hffff_fffc;
            #1;
            predict();
            n_checks++;
            if (dispatched !== em || branch_inst !== eb || fetch_ready !== exp_fr ||
                redirect_valid !== m_redir || redirect_pc !== m_rpc) begin
                n_fail++;
                $display("FAIL random_ctrl c=%0d: disp=%b br=%b fr=%b rv=%b rpc=%h, want %b %b %b %b %h",
                         c, dispatched, branch_inst, fetch_ready, redirect_valid, redirect_pc,
                         em, eb, exp_fr, m_redir, m_rpc);
            end
            for (int i = 0; i < exp_n; i++) begin
                n_checks++;
                if (dispatch_out[i].pc !== q[i].pc || dispatch_out[i].inst !== q[i].inst ||
                    dispatch_out[i].valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random_order c=%0d lane=%0d: pc=%h inst=%h, want %h %h",
                             c, i, dispatch_out[i].pc, dispatch_out[i].inst, q[i].pc, q[i].inst);
                end
            end
            tick();
        end
        // Drain remaining entries; nothing lost or duplicated
        branch_haz = 1'b0;
        set_fetch(0, '0);
        set_free(3, 3, 3);
        guard = 0;
        while (q.size() > 0 && guard < 12) begin
            #1;
            predict();
            n_checks++;
            if (dispatched !== em || dispatch_out[0].pc !== q[0].pc) begin
                n_fail++;
                $display("FAIL drain: disp=%b pc=%h, want %b %h", dispatched, dispatch_out[0].pc, em, q[0].pc);
            end
            tick();
            guard++;
        end
        #1;
        n_checks++;
        if (q.size() != 0 || dispatched !== 3'b000) begin
            n_fail++;
            $display("FAIL drain_end: left=%0d disp=%b, want 0 000", q.size(), dispatched);
        end
    endtask

    initial begin
        m_redir = 0;
        m_rpc   = '0;
        test_reset();
        test_basic_dispatch();
        test_free_limit();
        test_full();
        test_branch_limit();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
